cov_sample_scheduler: RTL and testbench
=======================================

# cov_sample_scheduler

Sequences coverage collection across up to NUM_SCOPES coverage-instrumented modules: clears their toggle/condition counters, opens a sampling window of programmable length by driving each scope's coverage enable, then reads each scope's covered-point count over a shared request/acknowledge port and sums the counts. It sits beside the instrumented design as the single hardware owner of coverage enable, clear and readout, replacing ad-hoc software toggling of the enables.

## Interface
- NUM_SCOPES, 4: number of instrumented scopes controlled (1..16)
- CNT_W, 16: width of one scope's covered-point count
- WIN_W, 16: width of the sampling-window length
- SEL_W, $clog2(NUM_SCOPES) (min 1): width of rd_sel

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a run; honoured only in IDLE
- abort  in  1  cancel the run in progress; returns to IDLE
- window_cycles  in  WIN_W  sampling window length in cycles, sampled at start
- scope_mask  in  NUM_SCOPES  scopes taking part, sampled at start
- cov_en  out  NUM_SCOPES  per-scope coverage enable
- cov_clr  out  NUM_SCOPES  per-scope one-cycle counter-clear pulse
- rd_req  out  1  count-read request
- rd_sel  out  SEL_W  scope index being read
- rd_ack  in  1  read acknowledge; rd_count valid in the same cycle
- rd_count  in  CNT_W  covered-point count of scope rd_sel
- total_count  out  CNT_W+SEL_W  sum of counts from the last completed run
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a run completes

## Operation
- States: IDLE, CLEAR, SAMPLE, READ, DONE.
- IDLE: all outputs low except total_count, which holds its value. start=1 latches window_cycles into win_left and scope_mask into mask_r, clears acc, and moves to CLEAR.
- CLEAR (1 cycle): cov_clr = mask_r. Next state is SAMPLE if win_left != 0, otherwise READ.
- SAMPLE: cov_en = mask_r. win_left decrements each cycle. The state exits to READ in the cycle where win_left == 1, so cov_en is high for exactly window_cycles cycles.
- READ: idx starts at the lowest set bit of mask_r. rd_req=1 and rd_sel=idx are held until rd_ack. On rd_ack, acc += rd_count (zero-extended) and idx advances to the next set bit. After the last set bit is acknowledged, go to DONE. If mask_r==0, READ lasts one cycle with rd_req low.
- DONE (1 cycle): done=1; total_count<=acc; then IDLE.
- abort=1 in any non-IDLE state: next state IDLE. cov_en, cov_clr and rd_req drop the next cycle. acc is discarded, total_count is unchanged and no done pulse occurs. abort has priority over rd_ack and window expiry in the same cycle.
- start outside IDLE is ignored. Mask and window changes mid-run have no effect.
- rd_ack while rd_req is low is ignored.
- acc width CNT_W+SEL_W cannot overflow; no saturation logic.
- reset: state IDLE; cov_en=0, cov_clr=0, rd_req=0, rd_sel=0, total_count=0, busy=0, done=0. Reset mid-run behaves like abort, except total_count is also cleared.

## Timing
- start sampled high at edge E: CLEAR is the cycle after E; cov_en high for cycles E+2 .. E+1+W.
- The first rd_req is asserted in cycle E+2+W.
- A read takes 1 cycle with same-cycle rd_ack, plus 1 cycle per wait cycle.
- For M masked scopes with immediate acks, done pulses at cycle E+2+W+M. total_count becomes valid in that same cycle and stays stable until the next done or reset.
- busy rises the cycle after E and falls the cycle after done.
- All outputs are registered; no combinational input-to-output paths except none required.

## Test plan
- Reset: assert reset 2 cycles mid-SAMPLE -> all outputs 0 next cycle, total_count=0, no done.
- Basic run: mask=4'b1011, window=5, acks immediate, counts 3/7/9 for scopes 0/1/3 -> cov_clr=1011 for 1 cycle; cov_en=1011 for exactly 5 cycles; rd_sel sequence 0,1,3; done at E+10; total_count=19.
- Edge cases: window=0 and mask=4'b0100 -> no cov_en cycle, single read of scope 2. Separately, mask=0 -> done at E+3, total_count=0.
- Ack back-pressure: scope 1 acks after 4 wait cycles -> rd_req and rd_sel held stable throughout, done delayed by 4 cycles. A stray rd_ack in IDLE -> ignored.
- Abort with rd_ack: abort in READ in the same cycle as rd_ack -> IDLE next cycle, no done, total_count retains prior value 19.
- Max counts: NUM_SCOPES=4, all counts 16'hFFFF -> total_count=18'h3FFFC. start pulsed during busy -> ignored, exactly one done.

Source files
------------

// File: rtl/cov_sample_scheduler.sv
// Coverage run sequencer: clears the instrumented scopes, enables them for a
// programmable window, then reads back and sums each scope's covered-point count.
module cov_sample_scheduler #(
    parameter int NUM_SCOPES = 4,
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16,
    parameter int SEL_W      = (NUM_SCOPES > 1) ? $clog2(NUM_SCOPES) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [WIN_W-1:0]         window_cycles,
    input  logic [NUM_SCOPES-1:0]    scope_mask,
    output logic [NUM_SCOPES-1:0]    cov_en,
    output logic [NUM_SCOPES-1:0]    cov_clr,
    output logic                     rd_req,
    output logic [SEL_W-1:0]         rd_sel,
    input  logic                     rd_ack,
    input  logic [CNT_W-1:0]         rd_count,
    output logic [CNT_W+SEL_W-1:0]   total_count,
    output logic                     busy,
    output logic                     done
);

    localparam int ACC_W = CNT_W + SEL_W;

    typedef enum logic [2:0] {IDLE, CLEAR, SAMPLE, READ, DONE} state_t;

    state_t                  state, next_state;
    logic [WIN_W-1:0]        win_left;
    logic [NUM_SCOPES-1:0]   mask_r;
    logic [NUM_SCOPES-1:0]   pend;
    logic [NUM_SCOPES-1:0]   pend_after;
    logic [NUM_SCOPES-1:0]   idx_onehot;
    logic [SEL_W-1:0]        idx;
    logic [ACC_W-1:0]        acc, acc_next, total_r;
    logic                    ack_take;

    // pend holds the scopes still to be read; idx is its lowest set bit
    always_comb begin
        idx        = '0;
        idx_onehot = '0;
        for (int i = NUM_SCOPES - 1; i >= 0; i--) begin
            if (pend[i]) begin
                idx        = SEL_W'(i);
                idx_onehot = NUM_SCOPES'(1) << i;
            end
        end
    end

    always_comb begin
        ack_take   = (state == READ) && (pend != '0) && rd_ack && !abort;
        acc_next   = acc + (ack_take ? ACC_W'(rd_count) : ACC_W'(0));
        pend_after = ack_take ? (pend & ~idx_onehot) : pend;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CLEAR;
            CLEAR:   next_state = (win_left != '0) ? SAMPLE : READ;
            SAMPLE:  if (win_left == WIN_W'(1)) next_state = READ;
            READ: begin
                if (pend == '0)
                    next_state = DONE;
                else if (ack_take && (pend_after == '0))
                    next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        // abort outranks both an acknowledge and window expiry
        if (abort && (state != IDLE))
            next_state = IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            win_left <= '0;
            mask_r   <= '0;
            pend     <= '0;
            acc      <= '0;
            total_r  <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (start) begin
                        win_left <= window_cycles;
                        mask_r   <= scope_mask;
                        pend     <= scope_mask;
                        acc      <= '0;
                    end
                end
                SAMPLE: win_left <= win_left - WIN_W'(1);
                READ: begin
                    acc  <= acc_next;
                    pend <= pend_after;
                end
                default: ;
            endcase
            // publish the sum as DONE is entered so it is valid alongside done
            if ((state == READ) && (next_state == DONE))
                total_r <= acc_next;
        end
    end

    always_comb begin
        cov_en      = '0;
        cov_clr     = '0;
        rd_req      = 1'b0;
        rd_sel      = '0;
        done        = 1'b0;
        busy        = (state != IDLE);
        total_count = total_r;
        case (state)
            CLEAR:  cov_clr = mask_r;
            SAMPLE: cov_en  = mask_r;
            READ: begin
                rd_req = (pend != '0);
                rd_sel = (pend != '0) ? idx : '0;
            end
            DONE:   done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cov_sample_scheduler.sv
// Self-checking bench for cov_sample_scheduler: table-driven runs scored through a
// queue, plus hand-written reset, abort and stray-acknowledge sequences.
module tb_cov_sample_scheduler;

    localparam int NS = 4;
    localparam int CW = 16;
    localparam int WW = 16;
    localparam int SW = 2;
    localparam int AW = CW + SW;

    logic          clock = 1'b0;
    logic          reset, start, abort, rd_ack, rd_req, busy, done;
    logic [WW-1:0] window_cycles;
    logic [NS-1:0] scope_mask, cov_en, cov_clr;
    logic [SW-1:0] rd_sel;
    logic [CW-1:0] rd_count;
    logic [AW-1:0] total_count;

    cov_sample_scheduler #(.NUM_SCOPES(NS), .CNT_W(CW), .WIN_W(WW)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .window_cycles(window_cycles), .scope_mask(scope_mask),
        .cov_en(cov_en), .cov_clr(cov_clr), .rd_req(rd_req), .rd_sel(rd_sel),
        .rd_ack(rd_ack), .rd_count(rd_count), .total_count(total_count),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [NS-1:0]         mask;
        logic [WW-1:0]         win;
        logic [NS-1:0][CW-1:0] cnt;
        logic [NS-1:0][3:0]    wt;
        logic [AW-1:0]         exp_total;
        int                    exp_lat;
        bit                    poke;
    } vec_t;

    typedef struct {
        logic [AW-1:0] total;
        int            lat;
        int            en;
        int            clr;
        logic [NS-1:0] mask;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];

    int pass_cnt = 0;
    int check_cnt = 0;

    logic [CW-1:0] cnt_tab [NS];
    int            wait_tab [NS];
    logic [NS-1:0] run_mask;
    bit            manual;
    logic          man_ack;
    logic [CW-1:0] man_count;

    int            wait_cnt, en_cycles, en_bad, clr_cycles, clr_bad, done_count, done_cyc, stab_err;
    logic [AW-1:0] done_total;
    int            sel_log[$];
    logic          prev_wait;
    logic [SW-1:0] prev_sel;

    int base_en, base_enbad, base_clr, base_clrbad, base_done, base_sel, base_stab, start_edge;

    // Scope responder and output monitor share one process so ack and logging agree
    initial begin : monitor
        rd_ack = 1'b0; rd_count = '0; wait_cnt = 0;
        en_cycles = 0; en_bad = 0; clr_cycles = 0; clr_bad = 0;
        done_count = 0; done_cyc = 0; stab_err = 0; done_total = '0;
        prev_wait = 1'b0; prev_sel = '0;
        forever begin
            @(negedge clock);
            if (manual) begin
                rd_ack = man_ack; rd_count = man_count;
            end else if (rd_req === 1'b1) begin
                if (wait_cnt >= wait_tab[rd_sel]) begin
                    rd_ack = 1'b1; rd_count = cnt_tab[rd_sel]; wait_cnt = 0;
                end else begin
                    rd_ack = 1'b0; rd_count = 16'hDEAD; wait_cnt++;
                end
            end else begin
                rd_ack = 1'b0; wait_cnt = 0;
            end
            if (prev_wait && !(rd_req === 1'b1 && rd_sel == prev_sel)) stab_err++;
            prev_wait = (rd_req === 1'b1) && !rd_ack;
            prev_sel  = rd_sel;
            if (rd_req === 1'b1 && rd_ack) sel_log.push_back(int'(rd_sel));
            if (cov_en != '0) begin
                en_cycles++;
                if (cov_en != run_mask) en_bad++;
            end
            if (cov_clr != '0) begin
                clr_cycles++;
                if (cov_clr != run_mask) clr_bad++;
            end
            if (done === 1'b1) begin
                done_count++; done_cyc = cyc; done_total = total_count;
            end
        end
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        for (int i = 0; i < NS; i++) begin
            cnt_tab[i]  = v.cnt[i];
            wait_tab[i] = int'(v.wt[i]);
        end
        e.total = v.exp_total;
        e.lat   = v.exp_lat;
        e.en    = (v.mask != '0) ? int'(v.win) : 0;
        e.clr   = (v.mask != '0) ? 1 : 0;
        e.mask  = v.mask;
        sb.push_back(e);
        run_mask    = v.mask;
        base_en     = en_cycles;  base_enbad  = en_bad;
        base_clr    = clr_cycles; base_clrbad = clr_bad;
        base_done   = done_count; base_sel    = sel_log.size();
        base_stab   = stab_err;
        @(posedge clock); #1;
        start = 1'b1; scope_mask = v.mask; window_cycles = v.win;
        @(posedge clock); #1;
        start_edge = cyc;
        start = 1'b0; scope_mask = ~v.mask; window_cycles = 16'd7;
        if (v.poke) begin
            @(posedge clock); #1;
            start = 1'b1; scope_mask = 4'b0001; window_cycles = '0;
            @(posedge clock); #1;
            start = 1'b0;
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        int   k;
        for (int t = 0; t < 300 && done_count == base_done; t++) @(posedge clock);
        if (done_count == base_done) $display("[TB] FAIL done_timeout: no done pulse within 300 cycles");
        repeat (6) @(posedge clock);
        #1;
        e = sb.pop_front();
        checkVal("done_pulses", 32'(done_count - base_done), 32'd1);
        checkVal("total_at_done", 32'(done_total), 32'(e.total));
        checkVal("done_latency", 32'(done_cyc - start_edge + 1), 32'(e.lat));
        checkVal("cov_en_cycles", 32'(en_cycles - base_en), 32'(e.en));
        checkVal("cov_en_value", 32'(en_bad - base_enbad), 32'd0);
        checkVal("cov_clr_cycles", 32'(clr_cycles - base_clr), 32'(e.clr));
        checkVal("cov_clr_value", 32'(clr_bad - base_clrbad), 32'd0);
        checkVal("read_count", 32'(sel_log.size() - base_sel), 32'($countones(e.mask)));
        k = 0;
        for (int i = 0; i < NS; i++) begin
            if (e.mask[i]) begin
                if (base_sel + k < sel_log.size())
                    checkVal("rd_sel_order", 32'(sel_log[base_sel + k]), 32'(i));
                k++;
            end
        end
        checkVal("req_stable", 32'(stab_err - base_stab), 32'd0);
        checkVal("busy_after", 32'(busy), 32'd0);
        checkVal("total_held", 32'(total_count), 32'(e.total));
    endtask

    initial begin : main
        int bd;
        bit seen;
        reset = 1'b1; start = 1'b0; abort = 1'b0; manual = 1'b0;
        man_ack = 1'b0; man_count = '0; run_mask = '0;
        window_cycles = '0; scope_mask = '0;
        for (int i = 0; i < NS; i++) begin cnt_tab[i] = '0; wait_tab[i] = 0; end

        vecs[0] = '{4'b1011, 16'd5, {16'd9, 16'd100, 16'd7, 16'd3}, {4'd0, 4'd0, 4'd0, 4'd0}, 18'd19, 10, 1'b0};
        vecs[1] = '{4'b0100, 16'd0, {16'd0, 16'h0042, 16'd0, 16'd0}, {4'd0, 4'd0, 4'd0, 4'd0}, 18'h42, 3, 1'b0};
        vecs[2] = '{4'b0000, 16'd0, {16'd1, 16'd1, 16'd1, 16'd1}, {4'd0, 4'd0, 4'd0, 4'd0}, 18'd0, 3, 1'b0};
        vecs[3] = '{4'b1011, 16'd3, {16'd9, 16'd100, 16'd7, 16'd3}, {4'd0, 4'd0, 4'd4, 4'd0}, 18'd19, 12, 1'b0};
        vecs[4] = '{4'b1111, 16'd2, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, {4'd0, 4'd0, 4'd0, 4'd0}, 18'h3FFFC, 8, 1'b1};
        vecs[5] = '{4'b0001, 16'd1, {16'd0, 16'd0, 16'd0, 16'd5}, {4'd0, 4'd0, 4'd0, 4'd2}, 18'd5, 6, 1'b0};
        vecs[6] = '{4'b1000, 16'd2, {16'h1234, 16'd0, 16'd0, 16'd0}, {4'd1, 4'd0, 4'd0, 4'd0}, 18'h1234, 6, 1'b0};

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        checkVal("reset_cov_en", 32'(cov_en), 32'd0);
        checkVal("reset_cov_clr", 32'(cov_clr), 32'd0);
        checkVal("reset_rd_req", 32'(rd_req), 32'd0);
        checkVal("reset_rd_sel", 32'(rd_sel), 32'd0);
        checkVal("reset_total", 32'(total_count), 32'd0);
        checkVal("reset_busy", 32'(busy), 32'd0);
        checkVal("reset_done", 32'(done), 32'd0);

        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v]);
            checkOutput();
        end

        // Acknowledge with no request outstanding must not disturb an idle scheduler
        bd = done_count;
        manual = 1'b1; man_ack = 1'b1; man_count = 16'h00FF;
        repeat (3) @(posedge clock);
        #1;
        checkVal("stray_ack_busy", 32'(busy), 32'd0);
        checkVal("stray_ack_req", 32'(rd_req), 32'd0);
        checkVal("stray_ack_total", 32'(total_count), 32'h1234);
        checkVal("stray_ack_done", 32'(done_count - bd), 32'd0);
        man_ack = 1'b0; manual = 1'b0;
        repeat (2) @(posedge clock);

        applyStimulus(vecs[0]);
        checkOutput();

        // Abort landing in the same cycle as an acknowledge
        manual = 1'b1; man_ack = 1'b0; man_count = '0;
        bd = done_count;
        @(posedge clock); #1;
        start = 1'b1; scope_mask = 4'b1011; window_cycles = 16'd1;
        @(posedge clock); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(posedge clock); #1;
            if (rd_req === 1'b1) seen = 1'b1;
        end
        checkVal("abort_reached_read", 32'(seen), 32'd1);
        man_ack = 1'b1; man_count = 16'd5; abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0; man_ack = 1'b0;
        checkVal("abort_busy", 32'(busy), 32'd0);
        checkVal("abort_rd_req", 32'(rd_req), 32'd0);
        checkVal("abort_total", 32'(total_count), 32'd19);
        repeat (10) @(posedge clock);
        #1;
        checkVal("abort_no_done", 32'(done_count - bd), 32'd0);
        manual = 1'b0;

        // Two-cycle reset in the middle of the sampling window
        for (int i = 0; i < NS; i++) begin cnt_tab[i] = 16'd1; wait_tab[i] = 0; end
        run_mask = 4'b1011;
        bd = done_count;
        @(posedge clock); #1;
        start = 1'b1; scope_mask = 4'b1011; window_cycles = 16'd20;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        checkVal("pre_reset_cov_en", 32'(cov_en), 32'hB);
        reset = 1'b1;
        @(posedge clock); #1;
        checkVal("midrun_reset_cov_en", 32'(cov_en), 32'd0);
        checkVal("midrun_reset_busy", 32'(busy), 32'd0);
        checkVal("midrun_reset_total", 32'(total_count), 32'd0);
        checkVal("midrun_reset_done", 32'(done), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (30) @(posedge clock);
        #1;
        checkVal("midrun_reset_no_done", 32'(done_count - bd), 32'd0);
        checkVal("midrun_reset_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
